cpu_req_queue: RTL and testbench

- Upstream request stage for the single-bus cache controller.
- Buffers processor load/store requests in a small FIFO and issues them one at a time to the controller's start/address/write_data/read_operation interface.
- Tracks the controller's cache_busy handshake and returns read data to the processor as a one-cycle response.
- Sits between the CPU/testbench driver and the cache controller inside the single-bus top level.

---
 rtl/cpu_req_queue_if.sv | 43 ++++
 rtl/cpu_req_queue.sv | 183 ++++++++++++++++++
 tb/tb_cpu_req_queue.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_req_queue_if.sv
`default_nettype none
// ======================================================================
// cpu_req_queue_if : processor request and cache-controller bus bundle
// Revision: 1.0
// ======================================================================
interface cpu_req_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          req_valid;
  logic          req_ready;
  logic          req_read;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic          read_operation;
  logic          start;
  logic          cache_busy;
  logic [DW-1:0] read_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          wr_done;
  logic [CW-1:0] q_count;

  // Driver side: CPU plus the cache controller.
  modport master (
    output req_valid, req_read, req_addr, req_wdata, cache_busy, read_data,
    input  req_ready, address, write_data, read_operation, start,
           rsp_valid, rsp_data, wr_done, q_count
  );

  // Queue side.
  modport slave (
    input  req_valid, req_read, req_addr, req_wdata, cache_busy, read_data,
    output req_ready, address, write_data, read_operation, start,
           rsp_valid, rsp_data, wr_done, q_count
  );
endinterface
`default_nettype wire

// File: rtl/cpu_req_queue.sv
`default_nettype none
// ======================================================================
// cpu_req_queue : CPU request FIFO issuing one access at a time to the
//   cache controller. Optional perf counters under REQ_PERF_CNT_EN.
// Revision: 1.0
// ======================================================================
module cpu_req_queue #(
  parameter int DEPTH     = 4,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int BUSY_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  cpu_req_queue_if.slave bus
`ifdef REQ_PERF_CNT_EN
  ,
  output logic [15:0]    rd_cnt,
  output logic [15:0]    wr_cnt,
  output logic [15:0]    busy_cyc
`endif
);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int EW  = 1 + AW + DW;
  localparam int WCW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(BUSY_WAIT - 1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t         state;
  logic [EW-1:0]  mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [WCW-1:0] wait_cnt;

  logic           start_pulse;
  logic           rsp_pulse;
  logic           wr_pulse;
  logic [DW-1:0]  rsp_value;
  logic [AW-1:0]  cur_addr;
  logic [DW-1:0]  cur_wdata;
  logic           cur_read;

  logic           push;
  logic           pop;
  logic           enter_resp;
  logic           head_read;
  logic [AW-1:0]  head_addr;
  logic [DW-1:0]  head_wdata;

  assign bus.req_ready      = (count != FULL_CNT);
  assign bus.q_count        = count;
  assign bus.start          = start_pulse;
  assign bus.rsp_valid      = rsp_pulse;
  assign bus.rsp_data       = rsp_value;
  assign bus.wr_done        = wr_pulse;
  assign bus.address        = cur_addr;
  assign bus.write_data     = cur_wdata;
  assign bus.read_operation = cur_read;

  assign push = bus.req_valid && bus.req_ready;
  assign pop  = (state == ISSUE);
  assign {head_read, head_addr, head_wdata} = mem[rd_ptr];

  // Busy has priority over the wait timeout, even on the final wait cycle.
  assign enter_resp = !bus.cache_busy &&
                      ((state == WAIT_DONE) ||
                       ((state == WAIT_BUSY) && (wait_cnt == WAIT_LAST)));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.req_read, bus.req_addr, bus.req_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      start_pulse <= 1'b0;
      rsp_pulse   <= 1'b0;
      wr_pulse    <= 1'b0;
      rsp_value   <= '0;
      cur_addr    <= '0;
      cur_wdata   <= '0;
      cur_read    <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      rsp_pulse   <= 1'b0;
      wr_pulse    <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state       <= ISSUE;
            start_pulse <= 1'b1;
            cur_addr    <= head_addr;
            cur_wdata   <= head_wdata;
            cur_read    <= head_read;
          end
        end
        ISSUE: begin
          state    <= WAIT_BUSY;
          wait_cnt <= '0;
        end
        WAIT_BUSY: begin
          if (bus.cache_busy) begin
            state <= WAIT_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.cache_busy) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (enter_resp) begin
        rsp_pulse <= cur_read;
        wr_pulse  <= !cur_read;
        if (cur_read) begin
          rsp_value <= bus.read_data;
        end
      end
    end
  end

`ifdef REQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      busy_cyc <= '0;
    end else begin
      if (rsp_pulse && (rd_cnt != 16'hFFFF)) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
      if (wr_pulse && (wr_cnt != 16'hFFFF)) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
      if (((state == WAIT_BUSY) || (state == WAIT_DONE)) && (busy_cyc != 16'hFFFF)) begin
        busy_cyc <= busy_cyc + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_req_queue.sv
`default_nettype none
// ======================================================================
// tb_cpu_req_queue : directed and random stimulus against a timestamp-based
//   reference model of the request queue and its issue timing.
// Revision: 1.0
// ======================================================================
module tb_cpu_req_queue;
  localparam int DEPTH     = 4;
  localparam int AW        = 8;
  localparam int DW        = 8;
  localparam int BUSY_WAIT = 4;

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_req_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

`ifdef REQ_PERF_CNT_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] busy_cyc;
`endif

  cpu_req_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef REQ_PERF_CNT_EN
    ,
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt),
    .busy_cyc (busy_cyc)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Stimulus for the next cycle.
  logic          nv_valid = 1'b0;
  logic          nv_read  = 1'b0;
  logic [AW-1:0] nv_addr  = '0;
  logic [DW-1:0] nv_wdata = '0;

  // Controller responder: busy window relative to the observed start.
  bit            cfg_rand  = 1'b0;
  int            cfg_dly   = 1;
  int            cfg_len   = 1;
  logic [DW-1:0] cfg_rdata = '0;
  bit            ctl_act   = 1'b0;
  int            ctl_s     = 0;
  int            ctl_dly   = 0;
  int            ctl_len   = 0;
  logic [DW-1:0] ctl_rdata = '0;

  // Reference model: request queue plus timestamps of the current access.
  req_t          mq[$];
  req_t          cur;
  bit            busy_iv   = 1'b0;
  bit            seen_busy = 1'b0;
  int            s_cyc     = 0;
  int            b_cyc     = 0;
  bit            e_start   = 1'b0;
  bit            e_rsp     = 1'b0;
  bit            e_wr      = 1'b0;
  logic [DW-1:0] e_data    = '0;
  bit            last_push = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    mq.delete();
    busy_iv   = 1'b0;
    seen_busy = 1'b0;
    e_start   = 1'b0;
    e_rsp     = 1'b0;
    e_wr      = 1'b0;
    e_data    = '0;
    ctl_act   = 1'b0;
  endtask

  task automatic step();
    bit push;
    bit resp_next;
    bit nxt_start;
    int d;
    @(posedge clk);
    cyc++;
    #1;
    bus.req_valid = nv_valid;
    bus.req_read  = nv_read;
    bus.req_addr  = nv_addr;
    bus.req_wdata = nv_wdata;
    d = cyc - ctl_s;
    bus.cache_busy = ctl_act && (ctl_dly != 0) && (d >= ctl_dly) && (d < ctl_dly + ctl_len);
    bus.read_data  = ctl_rdata;
    @(negedge clk);

    check("start", bus.start, e_start);
    check("rsp_valid", bus.rsp_valid, e_rsp);
    check("wr_done", bus.wr_done, e_wr);
    check("rsp_data", bus.rsp_data, e_data);
    check("q_count", bus.q_count, mq.size());
    check("req_ready", bus.req_ready, mq.size() != DEPTH);
    if (e_start && mq.size() != 0) begin
      check("issue_addr", bus.address, mq[0].a);
      check("issue_rd", bus.read_operation, mq[0].rd);
      if (!mq[0].rd) check("issue_wdata", bus.write_data, mq[0].d);
    end

    if (e_start) begin
      busy_iv   = 1'b1;
      s_cyc     = cyc;
      cur       = mq[0];
      seen_busy = 1'b0;
    end
    resp_next = 1'b0;
    if (busy_iv && !(e_rsp || e_wr) && cyc > s_cyc) begin
      if (!seen_busy) begin
        if (bus.cache_busy) begin
          seen_busy = 1'b1;
          b_cyc     = cyc;
        end else if (cyc - s_cyc == BUSY_WAIT) begin
          resp_next = 1'b1;
        end
      end else if (cyc > b_cyc && !bus.cache_busy) begin
        resp_next = 1'b1;
      end
    end
    nxt_start = !busy_iv && (mq.size() != 0);
    if (e_rsp || e_wr) busy_iv = 1'b0;
    push = bus.req_valid && (mq.size() != DEPTH);
    if (e_start) void'(mq.pop_front());
    if (push) mq.push_back('{rd: bus.req_read, a: bus.req_addr, d: bus.req_wdata});
    last_push = push;
    e_rsp = resp_next && cur.rd;
    e_wr  = resp_next && !cur.rd;
    if (resp_next && cur.rd) e_data = bus.read_data;
    e_start = nxt_start;

    if (bus.start) begin
      ctl_act = 1'b1;
      ctl_s   = cyc;
      if (cfg_rand) begin
        ctl_dly   = $urandom_range(0, BUSY_WAIT);
        ctl_len   = $urandom_range(1, 6);
        ctl_rdata = DW'($urandom);
      end else begin
        ctl_dly   = cfg_dly;
        ctl_len   = cfg_len;
        ctl_rdata = cfg_rdata;
      end
    end
  endtask

  task automatic push_req(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] dt);
    nv_valid = 1'b1;
    nv_read  = rd;
    nv_addr  = a;
    nv_wdata = dt;
    step();
    nv_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    nv_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit hold;
    bus.req_valid  = 1'b0;
    bus.req_read   = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.cache_busy = 1'b0;
    bus.read_data  = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_q_count", bus.q_count, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_start", bus.start, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_wr_done", bus.wr_done, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_address", bus.address, 0);
    check("rst_write_data", bus.write_data, 0);
    check("rst_read_op", bus.read_operation, 0);
    #1 rst = 1'b1;

    // Single read, busy one cycle after start for five cycles.
    cfg_dly = 1; cfg_len = 5; cfg_rdata = 8'hA5;
    push_req(1'b1, 8'h3C, 8'h00);
    idle(12);
    check("read_result", bus.rsp_data, 8'hA5);

    // Write completion.
    cfg_dly = 2; cfg_len = 3; cfg_rdata = 8'h5A;
    push_req(1'b0, 8'h10, 8'h77);
    idle(12);

    // Fill to full behind a long busy access, then push against a full queue.
    cfg_dly = 1; cfg_len = 30; cfg_rdata = 8'h11;
    push_req(1'b1, 8'hF0, 8'h00);
    idle(3);
    for (int i = 1; i <= 5; i++) push_req(1'b0, 8'(i), 8'(8'h20 + i));
    check("full_q_count", bus.q_count, DEPTH);
    check("full_req_ready", bus.req_ready, 0);
    cfg_len = 2;
    hold = 1'b1;
    nv_read = 1'b0; nv_addr = 8'h06; nv_wdata = 8'h66;
    for (int i = 0; i < 90; i++) begin
      nv_valid = hold;
      step();
      if (last_push) hold = 1'b0;
    end
    nv_valid = 1'b0;
    check("hold_accepted", hold, 0);

    // Busy never rises: timeout completion.
    cfg_dly = 0; cfg_len = 1; cfg_rdata = 8'hC3;
    push_req(1'b1, 8'h20, 8'h00);
    idle(10);
    check("nobusy_result", bus.rsp_data, 8'hC3);

    // Reset during WAIT_DONE with two entries queued.
    cfg_dly = 1; cfg_len = 40; cfg_rdata = 8'h99;
    push_req(1'b1, 8'h55, 8'h00);
    push_req(1'b1, 8'h61, 8'h00);
    push_req(1'b0, 8'h62, 8'h12);
    idle(5);
    check("pre_rst_q_count", bus.q_count, 2);
    #1 rst = 1'b0;
    #1;
    check("midrst_start", bus.start, 0);
    check("midrst_q_count", bus.q_count, 0);
    check("midrst_req_ready", bus.req_ready, 1);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_address", bus.address, 0);
    model_reset();
    #1 rst = 1'b1;
    idle(20);

    // Random traffic with random controller behaviour.
    cfg_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      nv_valid = ($urandom_range(0, 2) == 0);
      nv_read  = $urandom_range(0, 1) == 1;
      nv_addr  = AW'($urandom);
      nv_wdata = DW'($urandom);
      step();
    end
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
